// File: rtl/bram_resp_port.sv
// BRAM responder: host preload stream, controller BRAM port with registered reads, result dump.
// Optional BRAM_RESP_RANGE_CHECK_EN adds a sticky range_err output for misaligned/out-of-range access.
module bram_resp_port #(
  parameter int unsigned BRAM_ADDR_WIDTH = 15,
  parameter int unsigned DUMP_BASE       = 0,
  parameter int unsigned DUMP_WORDS      = 64
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [31:0] BRAM_ADDR,
  input  logic [31:0] BRAM_WRDATA,
  input  logic [3:0]  BRAM_WE,
  input  logic        BRAM_EN,
  input  logic        BRAM_RST,
  output logic [31:0] BRAM_RDDATA,
  input  logic        done,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        dp_valid,
  output logic [31:0] dp_data,
  output logic        dp_last,
  input  logic        dp_ready,
  output logic        busy
`ifdef BRAM_RESP_RANGE_CHECK_EN
  ,
  output logic        range_err
`endif
);

  localparam int unsigned IW    = BRAM_ADDR_WIDTH - 2;
  localparam int unsigned DEPTH = 2 ** IW;
  localparam int unsigned CW    = $clog2(DUMP_WORDS + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [1:0] {StLoad, StServe, StDump, StFin} state_e;

  logic [31:0] mem [DEPTH];

  state_e      state_q;
  idx_t        ld_ptr_q, rd_ptr_q;
  cnt_t        rd_cnt_q;
  logic        done_q;
  logic [31:0] rddata_q;
  logic        pf_valid_q, pf_last_q;
  logic [31:0] pf_data_q;
  logic        dp_valid_q, dp_last_q;
  logic [31:0] dp_data_q;

  idx_t        idx;
  logic        addr_bad;
  logic        ld_fire;
  logic        out_take;
  idx_t        wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  assign idx = BRAM_ADDR[BRAM_ADDR_WIDTH-1:2];

`ifdef BRAM_RESP_RANGE_CHECK_EN
  assign addr_bad = (BRAM_ADDR[1:0] != 2'b00) || ((BRAM_ADDR >> BRAM_ADDR_WIDTH) != 32'd0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      range_err <= 1'b0;
    end else if (state_q == StServe && BRAM_EN && addr_bad) begin
      range_err <= 1'b1;
    end
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{BRAM_ADDR[31:BRAM_ADDR_WIDTH], BRAM_ADDR[1:0]};
  assign addr_bad = 1'b0;
`endif

  // ld_ready drops combinationally with areset so no beat is taken while in reset.
  assign ld_ready = (state_q == StLoad) && !areset;
  assign ld_fire  = ld_valid && ld_ready;
  assign busy     = (state_q == StLoad) || (state_q == StDump);
  assign out_take = !dp_valid_q || dp_ready;

  assign BRAM_RDDATA = rddata_q;
  assign dp_valid    = dp_valid_q;
  assign dp_data     = dp_data_q;
  assign dp_last     = dp_last_q;

  always_comb begin
    wr_idx  = idx;
    wr_data = BRAM_WRDATA;
    wr_be   = 4'b0000;
    if (ld_fire) begin
      wr_idx  = ld_ptr_q;
      wr_data = ld_data;
      wr_be   = 4'b1111;
    end else if (state_q == StServe && BRAM_EN && !addr_bad) begin
      wr_be = BRAM_WE;
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= StLoad;
      ld_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_cnt_q   <= '0;
      done_q     <= 1'b0;
      rddata_q   <= '0;
      pf_valid_q <= 1'b0;
      pf_data_q  <= '0;
      pf_last_q  <= 1'b0;
      dp_valid_q <= 1'b0;
      dp_data_q  <= '0;
      dp_last_q  <= 1'b0;
    end else begin
      done_q <= done;
      unique case (state_q)
        StLoad: begin
          rddata_q <= '0;
          if (ld_fire) begin
            ld_ptr_q <= ld_ptr_q + 1'b1;
            if (ld_last) state_q <= StServe;
          end
        end
        StServe: begin
          // Nonblocking read of mem gives read-first behaviour on a same-word write.
          if (BRAM_RST) begin
            rddata_q <= '0;
          end else if (BRAM_EN) begin
            rddata_q <= addr_bad ? 32'd0 : mem[idx];
          end
          if (done && !done_q) begin
            state_q    <= StDump;
            rd_ptr_q   <= idx_t'(DUMP_BASE);
            rd_cnt_q   <= '0;
            pf_valid_q <= 1'b0;
            dp_valid_q <= 1'b0;
          end
        end
        StDump: begin
          if (out_take) begin
            dp_valid_q <= pf_valid_q;
            if (pf_valid_q) begin
              dp_data_q <= pf_data_q;
              dp_last_q <= pf_last_q;
            end
          end
          // Prefetch slot refills whenever it is empty or draining into the output register.
          if (!pf_valid_q || out_take) begin
            if (rd_cnt_q != cnt_t'(DUMP_WORDS)) begin
              pf_valid_q <= 1'b1;
              pf_data_q  <= mem[rd_ptr_q];
              pf_last_q  <= (rd_cnt_q == cnt_t'(DUMP_WORDS - 1));
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              rd_cnt_q   <= rd_cnt_q + 1'b1;
            end else begin
              pf_valid_q <= 1'b0;
            end
          end
          if (dp_valid_q && dp_ready && dp_last_q) begin
            state_q    <= StFin;
            dp_valid_q <= 1'b0;
            dp_last_q  <= 1'b0;
          end
        end
        StFin: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram_resp_port.sv
// Directed self-checking bench for bram_resp_port (default DUMP_BASE=0, DUMP_WORDS=64).
module tb_bram_resp_port;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] BRAM_ADDR, BRAM_WRDATA, BRAM_RDDATA;
  logic [3:0]  BRAM_WE;
  logic        BRAM_EN, BRAM_RST;
  logic        done, ld_valid, ld_last, ld_ready;
  logic [31:0] ld_data, dp_data;
  logic        dp_valid, dp_last, dp_ready, busy;
`ifdef BRAM_RESP_RANGE_CHECK_EN
  logic        range_err;
`endif

  int total = 0;
  int bad = 0;
  logic [31:0] exp_mem [64];

  always #5 aclk = ~aclk;

  bram_resp_port dut (
    .aclk(aclk), .areset(areset),
    .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
    .BRAM_EN(BRAM_EN), .BRAM_RST(BRAM_RST), .BRAM_RDDATA(BRAM_RDDATA),
    .done(done),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .dp_valid(dp_valid), .dp_data(dp_data), .dp_last(dp_last), .dp_ready(dp_ready),
    .busy(busy)
`ifdef BRAM_RESP_RANGE_CHECK_EN
    , .range_err(range_err)
`endif
  );

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic load_beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic bram_op(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we,
                         input logic en, input logic rst);
    BRAM_ADDR = a; BRAM_WRDATA = wd; BRAM_WE = we; BRAM_EN = en; BRAM_RST = rst;
    tick();
    BRAM_EN = 1'b0; BRAM_WE = 4'h0; BRAM_RST = 1'b0;
  endtask

  // Pulses done, checks the two-cycle start latency, then drains the dump against exp_mem.
  task automatic run_dump(input bit toggle);
    int k;
    bit r, stall;
    logic [31:0] stall_d;
    dp_ready = 1'b0;
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (dp_valid !== 1'b0) begin bad++; $display("FAIL dump_lat0 got=%b want=0", dp_valid); end
    tick();
    total++; if (dp_valid !== 1'b0) begin bad++; $display("FAIL dump_lat1 got=%b want=0", dp_valid); end
    tick();
    total++; if (dp_valid !== 1'b1) begin bad++; $display("FAIL dump_lat2 got=%b want=1", dp_valid); end
    k = 0; r = 1'b1; stall = 1'b0; stall_d = '0;
    for (int cyc = 0; cyc < 400 && k < 64; cyc++) begin
      if (stall) begin
        total++;
        if (dp_valid !== 1'b1 || dp_data !== stall_d) begin
          bad++; $display("FAIL dump_hold v=%b got=%h want=%h", dp_valid, dp_data, stall_d);
        end
      end
      dp_ready = r;
      if (dp_valid && r) begin
        total++;
        if (dp_data !== exp_mem[k]) begin
          bad++; $display("FAIL dump_data[%0d] got=%h want=%h", k, dp_data, exp_mem[k]);
        end
        total++;
        if (dp_last !== (k == 63)) begin
          bad++; $display("FAIL dump_last[%0d] got=%b want=%b", k, dp_last, (k == 63));
        end
        k++;
      end
      stall = dp_valid && !r;
      stall_d = dp_data;
      tick();
      if (toggle) r = ~r;
    end
    dp_ready = 1'b0;
    total++; if (k != 64) begin bad++; $display("FAIL dump_count got=%0d want=64", k); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fin_busy got=%b want=0", busy); end
    total++; if (dp_valid !== 1'b0) begin bad++; $display("FAIL fin_valid got=%b want=0", dp_valid); end
  endtask

  task automatic test_reset;
    areset = 1'b1;
    tick(); tick();
    total++; if (BRAM_RDDATA !== 32'h0) begin bad++; $display("FAIL rst_rddata got=%h want=0", BRAM_RDDATA); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL rst_ld_ready got=%b want=0", ld_ready); end
    total++; if (dp_valid !== 1'b0) begin bad++; $display("FAIL rst_dp_valid got=%b want=0", dp_valid); end
    total++; if (dp_data !== 32'h0) begin bad++; $display("FAIL rst_dp_data got=%h want=0", dp_data); end
    total++; if (dp_last !== 1'b0) begin bad++; $display("FAIL rst_dp_last got=%b want=0", dp_last); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b want=1", busy); end
    areset = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rel_ld_ready got=%b want=1", ld_ready); end
  endtask

  task automatic test_load;
    load_beat(32'h11, 1'b0); exp_mem[0] = 32'h11;
    load_beat(32'h22, 1'b0); exp_mem[1] = 32'h22;
    load_beat(32'h33, 1'b0); exp_mem[2] = 32'h33;
    load_beat(32'h44, 1'b1); exp_mem[3] = 32'h44;
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL serve_ld_ready got=%b want=0", ld_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL serve_busy got=%b want=0", busy); end
    bram_op(32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
    total++; if (BRAM_RDDATA !== 32'h33) begin bad++; $display("FAIL read_w2 got=%h want=33", BRAM_RDDATA); end
  endtask

  task automatic test_byte_write;
    bram_op(32'h4, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
    total++; if (BRAM_RDDATA !== 32'h22) begin bad++; $display("FAIL rd_first got=%h want=22", BRAM_RDDATA); end
    exp_mem[1] = 32'h00BB00DD;
    bram_op(32'h4, 32'h0, 4'h0, 1'b1, 1'b0);
    total++; if (BRAM_RDDATA !== 32'h00BB00DD) begin bad++; $display("FAIL byte_we got=%h want=00bb00dd", BRAM_RDDATA); end
  endtask

  task automatic test_fill;
    for (int i = 4; i < 64; i++) begin
      exp_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5000000;
      bram_op(32'(i) * 4, exp_mem[i], 4'hF, 1'b1, 1'b0);
    end
    bram_op(32'd63 * 4, 32'h0, 4'h0, 1'b1, 1'b0);
    total++; if (BRAM_RDDATA !== exp_mem[63]) begin bad++; $display("FAIL fill_w63 got=%h want=%h", BRAM_RDDATA, exp_mem[63]); end
  endtask

  task automatic test_enable_rst;
    bram_op(32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    total++; if (BRAM_RDDATA !== 32'h11) begin bad++; $display("FAIL read_w0 got=%h want=11", BRAM_RDDATA); end
    bram_op(32'h8, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    total++; if (BRAM_RDDATA !== 32'h11) begin bad++; $display("FAIL en0_hold got=%h want=11", BRAM_RDDATA); end
    bram_op(32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
    total++; if (BRAM_RDDATA !== 32'h33) begin bad++; $display("FAIL en0_nowrite got=%h want=33", BRAM_RDDATA); end
    bram_op(32'h8, 32'h0, 4'h0, 1'b0, 1'b1);
    total++; if (BRAM_RDDATA !== 32'h0) begin bad++; $display("FAIL rst_noen got=%h want=0", BRAM_RDDATA); end
    bram_op(32'h8, 32'h0, 4'h0, 1'b1, 1'b0);
    bram_op(32'h8, 32'h0, 4'h0, 1'b1, 1'b1);
    total++; if (BRAM_RDDATA !== 32'h0) begin bad++; $display("FAIL rst_en got=%h want=0", BRAM_RDDATA); end
  endtask

  task automatic test_range;
    bram_op(32'h0000_8000, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0);
`ifdef BRAM_RESP_RANGE_CHECK_EN
    total++; if (range_err !== 1'b1) begin bad++; $display("FAIL range_err got=%b want=1", range_err); end
    total++; if (BRAM_RDDATA !== 32'h0) begin bad++; $display("FAIL range_rd got=%h want=0", BRAM_RDDATA); end
`else
    exp_mem[0] = 32'hCAFEF00D;
`endif
    bram_op(32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    total++; if (BRAM_RDDATA !== exp_mem[0]) begin bad++; $display("FAIL range_w0 got=%h want=%h", BRAM_RDDATA, exp_mem[0]); end
  endtask

  task automatic test_dump;
    run_dump(1'b1);
  endtask

  task automatic test_fin_ignore;
    done = 1'b1;
    tick();
    done = 1'b0;
    tick(); tick(); tick();
    total++; if (dp_valid !== 1'b0) begin bad++; $display("FAIL fin_done_valid got=%b want=0", dp_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fin_done_busy got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid_dump;
    int k;
    areset = 1'b1;
    tick();
    areset = 1'b0;
    load_beat(32'h77, 1'b1); exp_mem[0] = 32'h77;
    dp_ready = 1'b1;
    done = 1'b1;
    tick();
    done = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 50 && k < 10; cyc++) begin
      if (dp_valid) k++;
      tick();
    end
    total++; if (k != 10) begin bad++; $display("FAIL mid_beats got=%0d want=10", k); end
    areset = 1'b1;
    #1;
    total++; if (dp_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", dp_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
    total++; if (ld_ready !== 1'b0) begin bad++; $display("FAIL mid_ld_ready got=%b want=0", ld_ready); end
    tick();
    areset = 1'b0;
    dp_ready = 1'b0;
    #1;
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL mid_load got=%b want=1", ld_ready); end
    load_beat(32'h99, 1'b1); exp_mem[0] = 32'h99;
    run_dump(1'b0);
  endtask

  initial begin
    areset = 1'b1;
    BRAM_ADDR = '0; BRAM_WRDATA = '0; BRAM_WE = '0; BRAM_EN = 1'b0; BRAM_RST = 1'b0;
    done = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; dp_ready = 1'b0;
    test_reset();
    test_load();
    test_byte_write();
    test_fill();
    test_enable_rst();
    test_range();
    test_dump();
    test_fin_ignore();
    test_reset_mid_dump();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
